load_store_unit: RTL and testbench

Sits between the CPU memory stage and the word-organised data memory. Converts byte/halfword/word load and store requests on byte addresses into word-indexed memory accesses. Loads get lane extraction and sign/zero extension; sub-word stores get a read-modify-write sequence. Drives the memory's Address/MemRead/MemWrite/WriteData inputs and consumes its combinational Data output.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Size codes, FSM state encoding and lane geometry.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int OFF_W  = 2;
  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR
  } lsu_state_t;

  // Reserved size code 2'b11 is handled as a word.
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction with sign/zero extension for loads and
// lane merge for sub-word stores (little-endian lanes).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0]      word,
  input  logic [31:0]      wdata,
  input  logic [1:0]       size,
  input  logic [OFF_W-1:0] off,
  input  logic             sign_ext,
  output logic [31:0]      ext,
  output logic [31:0]      merged
);

  logic [4:0]        bsh;
  logic [4:0]        hsh;
  logic [LANE_W-1:0] b;
  logic [15:0]       h;

  assign bsh = {off, 3'b000};
  assign hsh = {off[1], 4'b0000};
  assign b   = word[bsh +: LANE_W];
  assign h   = word[hsh +: 16];

  // Extract the addressed lane and extend it to 32 bits
  always_comb begin
    ext = word;
    unique case (1'b1)
      is_word(size):     ext = word;
      (size == SZ_HALF): ext = {{16{sign_ext & h[15]}}, h};
      default:           ext = {{24{sign_ext & b[7]}}, b};
    endcase
  end

  // Replace the addressed lane(s) of the old word with store data
  always_comb begin
    merged = word;
    unique case (1'b1)
      is_word(size):     merged = wdata;
      (size == SZ_HALF): merged[hsh +: 16] = wdata[15:0];
      default:           merged[bsh +: LANE_W] = wdata[7:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-indexed memory.
// Define MISALIGN_TRAP_EN to trap misaligned accesses with fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;
  logic [31:0]       ext;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] addr_in;
  logic              trap;

`ifdef MISALIGN_TRAP_EN
  assign trap = is_word(size) ? (|addr[1:0])
                              : ((size == SZ_HALF) & addr[0]);
`else
  assign trap = 1'b0;
`endif

  // Force low address bits to the natural alignment of the size
  always_comb begin
    addr_in = addr;
    unique case (1'b1)
      is_word(size):     addr_in[1:0] = 2'b00;
      (size == SZ_HALF): addr_in[0]   = 1'b0;
      default:           addr_in      = addr;
    endcase
  end

  lsu_lane_align u_align (
    .word     (mem_rdata),
    .wdata    (wdata_q),
    .size     (size_q),
    .off      (addr_q[OFF_W-1:0]),
    .sign_ext (sx_q),
    .ext      (ext),
    .merged   (merged)
  );

  // Request capture, sequencing and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      sx_q     <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= addr_in;
            size_q  <= size;
            sx_q    <= sign_ext;
            wdata_q <= wdata;
            if (trap) begin
              done  <= 1'b1;
              fault <= 1'b1;
            end else if (!we) begin
              state <= ST_LOAD;
            end else if (is_word(size)) begin
              state <= ST_STORE;
            end else begin
              state <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          rdata <= ext;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_STORE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_RMW_RD: begin
          merged_q <= merged;
          state    <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state == ST_IDLE);
  assign mem_addr  = {2'b00, addr_q[ADDR_W-1:2]};
  assign mem_read  = (state == ST_LOAD) || (state == ST_RMW_RD);
  assign mem_write = (state == ST_STORE) || (state == ST_RMW_WR);

  // Write data is only driven in the two write states
  always_comb begin
    mem_wdata = '0;
    unique case (state)
      ST_STORE:  mem_wdata = wdata_q;
      ST_RMW_WR: mem_wdata = merged_q;
      default:   mem_wdata = '0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array model.
// Honours MISALIGN_TRAP_EN for misaligned-access expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, fault, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic [7:0]  refm [0:1023];
  logic [31:0] last_rdata = '0;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int wa, input logic [31:0] v);
    mem[wa] = v;
    for (int k = 0; k < 4; k++) refm[4*wa+k] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int wa);
    int unsigned x = 0;
    for (int k = 3; k >= 0; k--) x = x * 256 + refm[4*wa+k];
    return 32'(x);
  endfunction

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz,
                                           input logic sx);
    int x;
    if (sz == 2'b00) begin
      x = int'(refm[a]);
      if (sx && x >= 128) x -= 256;
      return 32'(x);
    end else if (sz == 2'b01) begin
      x = int'(refm[a]) + 256 * int'(refm[a+1]);
      if (sx && x >= 32768) x -= 65536;
      return 32'(x);
    end
    return ref_word(a / 4);
  endfunction

  task automatic ref_store(input int a, input logic [1:0] sz,
                           input logic [31:0] d);
    int nb;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int k = 0; k < nb; k++) refm[a+k] = d[8*k +: 8];
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input int a, input logic [31:0] d, input string tag);
    bit trap;
    int ea, n, r0, w0, exp_n, exp_r, exp_w;
    logic [31:0] exp_rd;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'b01) trap = (a % 2) != 0;
    if (sz[1]) trap = (a % 4) != 0;
`endif
    ea = (sz == 2'b00) ? a : (sz == 2'b01) ? (a / 2) * 2 : (a / 4) * 4;
    exp_n = trap ? 0 : (w && !sz[1]) ? 2 : 1;
    exp_r = trap ? 0 : (!w || !sz[1]) ? 1 : 0;
    exp_w = (trap || !w) ? 0 : 1;
    exp_rd = (!w && !trap) ? ref_load(ea, sz, sx) : last_rdata;
    @(negedge clk);
    chk({tag, " ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; size = sz; sign_ext = sx;
    addr = 32'(a); wdata = d;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_done(n);
    chk({tag, " lat"}, 32'(n), 32'(exp_n));
    chk({tag, " rdata"}, rdata, exp_rd);
    chk({tag, " fault"}, 32'(fault), 32'(trap));
    chk({tag, " reads"}, 32'(rd_cnt - r0), 32'(exp_r));
    chk({tag, " writes"}, 32'(wr_cnt - w0), 32'(exp_w));
    if (w && !trap) ref_store(ea, sz, d);
    last_rdata = exp_rd;
  endtask

  task automatic rst_mid(input int edges, input string tag);
    int w0;
    poke(4, 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h11; wdata = 32'hAB;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (edges) @(posedge clk);
    @(negedge clk);
    if (edges == 0) chk({tag, " in rd"}, 32'(mem_read), 32'd1);
    else chk({tag, " in wr"}, 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk({tag, " ready"}, 32'(ready), 32'd1);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " fault"}, 32'(fault), 32'd0);
    chk({tag, " rdata"}, rdata, 32'd0);
    chk({tag, " mrd"}, 32'(mem_read), 32'd0);
    chk({tag, " mwr"}, 32'(mem_write), 32'd0);
    chk({tag, " maddr"}, mem_addr, 32'd0);
    chk({tag, " mwdata"}, mem_wdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    chk({tag, " no done"}, 32'(done), 32'd0);
    chk({tag, " mem"}, mem[4], 32'h11223344);
    chk({tag, " wcnt"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) poke(i, $urandom);

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst done", 32'(done), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst mrd", 32'(mem_read), 32'd0);
    chk("rst mwr", 32'(mem_write), 32'd0);
    chk("rst maddr", mem_addr, 32'd0);
    chk("rst mwdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    poke(4, 32'h80FF7F01);
    access(0, 2'b00, 1, 'h10, 0, "lb10");
    chk("lb10 const", rdata, 32'h00000001);
    access(0, 2'b00, 1, 'h11, 0, "lb11");
    chk("lb11 const", rdata, 32'h0000007F);
    access(0, 2'b00, 1, 'h12, 0, "lb12");
    chk("lb12 const", rdata, 32'hFFFFFFFF);
    access(0, 2'b00, 0, 'h13, 0, "lbu13");
    chk("lbu13 const", rdata, 32'h00000080);

    poke(4, 32'h11223344);
    access(1, 2'b00, 0, 'h11, 32'hAB, "sb11");
    chk("sb11 mem", mem[4], 32'h1122AB44);

    poke(8, 32'h0);
    access(1, 2'b01, 0, 'h22, 32'hBEEF, "sh22");
    chk("sh22 mem", mem[8], 32'hBEEF0000);
    access(0, 2'b01, 0, 'h22, 0, "lhu22");
    chk("lhu22 const", rdata, 32'h0000BEEF);
    access(0, 2'b01, 1, 'h22, 0, "lh22");
    chk("lh22 const", rdata, 32'hFFFFBEEF);

    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
    addr = 32'h40; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    we = 1'b0;
    wait_done(n);
    chk("b2b sw lat", 32'(n), 32'd1);
    chk("b2b ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("b2b accepted", 32'(ready), 32'd0);
    wait_done(n);
    chk("b2b lw lat", 32'(n), 32'd1);
    chk("b2b lw data", rdata, 32'hDEADBEEF);
    ref_store('h40, 2'b10, 32'hDEADBEEF);
    last_rdata = 32'hDEADBEEF;

    poke(24, 32'hA5A5A5A5);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h50; wdata = 32'h3C;
    @(posedge clk);
    #1;
    size = 2'b10; addr = 32'h60; wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_done(n);
    chk("spur lat", 32'(n), 32'd1);
    ref_store('h50, 2'b00, 32'h3C);
    repeat (3) @(negedge clk);
    chk("spur ignored", mem[24], 32'hA5A5A5A5);
    chk("spur sb mem", mem[20], ref_word(20));

    rst_mid(0, "rst rmwrd");
    rst_mid(1, "rst rmwwr");

    poke(1, 32'hCAFEF00D);
    access(0, 2'b10, 0, 'h06, 0, "lw06");
`ifndef MISALIGN_TRAP_EN
    chk("lw06 const", rdata, 32'hCAFEF00D);
`endif

    access(1, 2'b11, 0, 'h80, 32'h0BADF00D, "sw res");
    access(0, 2'b11, 1, 'h80, 0, "lw res");
    chk("lw res const", rdata, 32'h0BADF00D);

    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
             $urandom, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++) chk($sformatf("mem%0d", i), mem[i], ref_word(i));
    chk("rd&wr overlap", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
